sensor_trace_capture: RTL and testbench

SENSOR_TRACE_CAPTURE -- requirements
Module: sensor_trace_capture

---
 rtl/sensor_pkg.sv | 16 +
 rtl/sensor_popcount48.sv | 16 +
 rtl/sensor_trace_capture.sv | 160 ++++++++++++++++
 tb/tb_sensor_trace_capture.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sensor_pkg.sv
// Shared defaults and FSM state encoding for the sensor trace capture block.
package sensor_pkg;

  localparam int unsigned P_W_DEF      = 48;
  localparam int unsigned SAMPLE_W_DEF = 8;
  localparam int unsigned DEPTH_DEF    = 1024;
  localparam int unsigned PC_W         = 6;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/sensor_popcount48.sv
// Combinational population count of a 48-bit sensor word.
module sensor_popcount48
  import sensor_pkg::*;
(
  input  logic [47:0]     din,
  output logic [PC_W-1:0] cnt_c
);

  always_comb begin
    cnt_c = '0;
    for (int i = 0; i < 48; i++) begin
      cnt_c = cnt_c + PC_W'(din[i]);
    end
  end

endmodule

// File: rtl/sensor_trace_capture.sv
// Arm/trigger trace capture of popcount(P) into a sample buffer with sequential readback.
// Optional SENSOR_DECIM_EN: sum 4 consecutive raw samples per stored sample.
module sensor_trace_capture
  import sensor_pkg::*;
#(
  parameter int unsigned P_W      = P_W_DEF,
  parameter int unsigned DEPTH    = DEPTH_DEF,
  parameter int unsigned SAMPLE_W = SAMPLE_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [P_W-1:0]           P,
  input  logic                     arm,
  input  logic                     trig,
  input  logic [$clog2(DEPTH)-1:0] trace_len,
  input  logic                     rd_req,
  output logic [SAMPLE_W-1:0]      rd_data,
  output logic                     rd_valid,
  output logic                     rd_last,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned PTR_W = AW + 1;

  state_t              state;
  logic [P_W-1:0]      p_q;
  logic [AW-1:0]       len_q;
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [PTR_W-1:0]    n_samples_c;
  logic [PC_W-1:0]     pc_c;
  logic [SAMPLE_W-1:0] raw_c;
  logic [SAMPLE_W-1:0] wdata_c;
  logic                we_c;
  logic                last_wr_c;
  logic                rd_ok_c;

  logic [SAMPLE_W-1:0] mem [DEPTH];

  // Sensor word pipeline register; sample 0 is the word present at the trigger edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_q <= '0;
    end else begin
      p_q <= P;
    end
  end

  sensor_popcount48 u_popcount (
    .din   (48'(p_q)),
    .cnt_c (pc_c)
  );

  assign raw_c = SAMPLE_W'(pc_c);

`ifdef SENSOR_DECIM_EN
  logic [1:0]          phase_q;
  logic [SAMPLE_W-1:0] acc_q;

  // Every 4th capture cycle stores the running sum plus the current raw sample.
  assign we_c    = (state == ST_CAPTURE) && (phase_q == 2'd3);
  assign wdata_c = acc_q + raw_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q <= '0;
      acc_q   <= '0;
    end else if (state != ST_CAPTURE || we_c) begin
      phase_q <= '0;
      acc_q   <= '0;
    end else begin
      phase_q <= phase_q + 2'd1;
      acc_q   <= wdata_c;
    end
  end
`else
  assign we_c    = (state == ST_CAPTURE);
  assign wdata_c = raw_c;
`endif

  assign n_samples_c = PTR_W'(len_q) + PTR_W'(1);
  assign last_wr_c   = we_c && (wr_ptr[AW-1:0] == len_q);
  assign rd_ok_c     = rd_req && (rd_ptr != n_samples_c);

  // Buffer write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (we_c) begin
      mem[wr_ptr[AW-1:0]] <= wdata_c;
    end
  end

  // Control FSM with registered status and read port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      len_q    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (arm) begin
            state  <= ST_ARMED;
            len_q  <= trace_len;
            wr_ptr <= '0;
            rd_ptr <= '0;
            busy   <= 1'b1;
            done   <= 1'b0;
          end
        end
        ST_ARMED: begin
          if (trig) begin
            state <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (we_c) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
          end
          if (last_wr_c) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          // A new arm wins over a coincident read request.
          if (arm) begin
            state  <= ST_ARMED;
            len_q  <= trace_len;
            wr_ptr <= '0;
            rd_ptr <= '0;
            busy   <= 1'b1;
            done   <= 1'b0;
          end else if (rd_ok_c) begin
            rd_data  <= mem[rd_ptr[AW-1:0]];
            rd_valid <= 1'b1;
            rd_last  <= (rd_ptr[AW-1:0] == len_q);
            rd_ptr   <= rd_ptr + PTR_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sensor_trace_capture.sv
// Scoreboard bench for sensor_trace_capture; define SENSOR_DECIM_EN to exercise the decimating build.
module tb_sensor_trace_capture;

  logic        clk;
  logic        rst;
  logic [47:0] P;
  logic        arm;
  logic        trig;
  logic [9:0]  trace_len;
  logic        rd_req;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        rd_last;
  logic        busy;
  logic        done;

  int         checks;
  int         errors;
  logic [7:0] sb [$];

  sensor_trace_capture dut (
    .clk       (clk),
    .rst       (rst),
    .P         (P),
    .arm       (arm),
    .trig      (trig),
    .trace_len (trace_len),
    .rd_req    (rd_req),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_last   (rd_last),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_arm(input logic [9:0] len);
    arm       = 1'b1;
    trace_len = len;
    step();
    arm       = 1'b0;
  endtask

  task automatic read_one(output logic v, output logic [7:0] d, output logic l);
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    v = rd_valid;
    d = rd_data;
    l = rd_last;
  endtask

  task automatic test_reset();
    rst = 1'b0; P = '0; arm = 1'b0; trig = 1'b0; trace_len = '0; rd_req = 1'b0;
    #3;
    checks++;
    if ({rd_data, rd_valid, rd_last, busy, done} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 000", {rd_data, rd_valid, rd_last, busy, done});
    end
    step();
    rst = 1'b1;
    step();
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL reset_idle: busy/done=%b required 00", {busy, done});
    end
  endtask

`ifndef SENSOR_DECIM_EN
  // Drives trig on the first cycle and n sensor words; pushes the expected stored samples.
  task automatic drive_capture(input int n, input int mode, input int arm_at, output bit early_done);
    logic [47:0] pv;
    logic [7:0]  e;
    early_done = 1'b0;
    for (int k = 0; k < n; k++) begin
      case (mode)
        0:       begin pv = 48'h0000_0000_FFFF; e = 8'd16; end
        1:       begin pv = (48'd1 << k) - 48'd1; e = 8'(k); end
        default: begin pv = 48'({$urandom(), $urandom()}); e = 8'($countones(pv)); end
      endcase
      P    = pv;
      trig = (k == 0);
      arm  = (k == arm_at);
      if (k == arm_at) trace_len = 10'd20;
      sb.push_back(e);
      step();
      if (done) early_done = 1'b1;
    end
    trig = 1'b0;
    arm  = 1'b0;
    P    = 48'({$urandom(), $urandom()});
    step();
  endtask

  task automatic test_constant();
    bit early; logic v, l; logic [7:0] d, e;
    pulse_arm(10'd7);
    checks++;
    if ({busy, done} !== 2'b10) begin
      errors++; $display("FAIL const_armed: busy/done=%b required 10", {busy, done});
    end
    drive_capture(8, 0, -1, early);
    checks++;
    if (early !== 1'b0) begin
      errors++; $display("FAIL const_done_early: done seen before sample 7 was written");
    end
    checks++;
    if ({busy, done} !== 2'b01) begin
      errors++; $display("FAIL const_done: busy/done=%b required 01", {busy, done});
    end
    for (int i = 0; i < 8; i++) begin
      read_one(v, d, l);
      e = sb.pop_front();
      checks++;
      if (v !== 1'b1 || d !== e || l !== (i == 7)) begin
        errors++;
        $display("FAIL const_read%0d: valid=%b data=%0d last=%b required valid=1 data=%0d last=%b",
                 i, v, d, l, e, (i == 7));
      end
    end
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL const_done_after_read: done=%b required 1", done);
    end
  endtask

  task automatic test_incrementing();
    bit early; logic v, l; logic [7:0] d, e;
    pulse_arm(10'd47);
    drive_capture(48, 1, -1, early);
    checks++;
    if (early !== 1'b0 || done !== 1'b1) begin
      errors++; $display("FAIL incr_done: early=%b done=%b required early=0 done=1", early, done);
    end
    for (int i = 0; i < 48; i++) begin
      read_one(v, d, l);
      e = sb.pop_front();
      checks++;
      if (v !== 1'b1 || d !== e || l !== (i == 47)) begin
        errors++;
        $display("FAIL incr_read%0d: valid=%b data=%0d last=%b required valid=1 data=%0d last=%b",
                 i, v, d, l, e, (i == 47));
      end
    end
  endtask

  task automatic test_trig_before_arm();
    bit early; logic v, l; logic [7:0] d, e;
    trig = 1'b1;
    step();
    trig = 1'b0;
    checks++;
    if ({busy, done} !== 2'b01) begin
      errors++; $display("FAIL trig_in_done: busy/done=%b required 01", {busy, done});
    end
    pulse_arm(10'd3);
    repeat (6) step();
    checks++;
    if ({busy, done} !== 2'b10) begin
      errors++; $display("FAIL armed_holds: busy/done=%b required 10", {busy, done});
    end
    drive_capture(4, 2, 2, early);
    checks++;
    if (early !== 1'b0 || {busy, done} !== 2'b01) begin
      errors++; $display("FAIL arm_in_capture: early=%b busy/done=%b required early=0 01", early, {busy, done});
    end
    for (int i = 0; i < 4; i++) begin
      read_one(v, d, l);
      e = sb.pop_front();
      checks++;
      if (v !== 1'b1 || d !== e || l !== (i == 3)) begin
        errors++;
        $display("FAIL rearm_read%0d: valid=%b data=%0d last=%b required valid=1 data=%0d last=%b",
                 i, v, d, l, e, (i == 3));
      end
    end
    read_one(v, d, l);
    checks++;
    if (v !== 1'b0) begin
      errors++; $display("FAIL rearm_extra_read: valid=%b required 0", v);
    end
  endtask

  task automatic test_overread_arm_priority();
    bit early; logic v, l; logic [7:0] d, e, last_e;
    pulse_arm(10'd7);
    drive_capture(8, 2, -1, early);
    last_e = '0;
    for (int i = 0; i < 8; i++) begin
      read_one(v, d, l);
      e = sb.pop_front();
      last_e = e;
      checks++;
      if (v !== 1'b1 || d !== e || l !== (i == 7)) begin
        errors++;
        $display("FAIL rand_read%0d: valid=%b data=%0d last=%b required valid=1 data=%0d last=%b",
                 i, v, d, l, e, (i == 7));
      end
    end
    read_one(v, d, l);
    checks++;
    if (v !== 1'b0 || d !== last_e) begin
      errors++; $display("FAIL ninth_read: valid=%b data=%0d required valid=0 data=%0d", v, d, last_e);
    end
    pulse_arm(10'd1);
    drive_capture(2, 2, -1, early);
    read_one(v, d, l);
    e = sb.pop_front();
    checks++;
    if (v !== 1'b1 || d !== e || l !== 1'b0) begin
      errors++; $display("FAIL pre_arm_read: valid=%b data=%0d last=%b required valid=1 data=%0d last=0", v, d, l, e);
    end
    sb.delete();
    arm = 1'b1; rd_req = 1'b1; trace_len = 10'd3;
    step();
    arm = 1'b0; rd_req = 1'b0;
    checks++;
    if (rd_valid !== 1'b0 || {busy, done} !== 2'b10) begin
      errors++; $display("FAIL arm_vs_read: valid=%b busy/done=%b required valid=0 10", rd_valid, {busy, done});
    end
    read_one(v, d, l);
    checks++;
    if (v !== 1'b0) begin
      errors++; $display("FAIL read_in_armed: valid=%b required 0", v);
    end
    drive_capture(4, 2, -1, early);
    for (int i = 0; i < 4; i++) begin
      read_one(v, d, l);
      e = sb.pop_front();
      checks++;
      if (v !== 1'b1 || d !== e || l !== (i == 3)) begin
        errors++;
        $display("FAIL post_arm_read%0d: valid=%b data=%0d last=%b required valid=1 data=%0d last=%b",
                 i, v, d, l, e, (i == 3));
      end
    end
  endtask

  task automatic test_full_depth();
    bit early; logic v, l; logic [7:0] d, e;
    int bad;
    bad = 0;
    pulse_arm(10'd1023);
    drive_capture(1024, 2, -1, early);
    checks++;
    if (early !== 1'b0 || {busy, done} !== 2'b01) begin
      errors++; $display("FAIL full_done: early=%b busy/done=%b required early=0 01", early, {busy, done});
    end
    for (int i = 0; i < 1024; i++) begin
      read_one(v, d, l);
      e = sb.pop_front();
      checks++;
      if (v !== 1'b1 || d !== e || l !== (i == 1023)) begin
        errors++;
        if (bad < 8)
          $display("FAIL full_read%0d: valid=%b data=%0d last=%b required valid=1 data=%0d last=%b",
                   i, v, d, l, e, (i == 1023));
        bad++;
      end
    end
    read_one(v, d, l);
    checks++;
    if (v !== 1'b0) begin
      errors++; $display("FAIL full_extra_read: valid=%b required 0", v);
    end
  endtask

  task automatic test_rst_mid_capture();
    logic v, l; logic [7:0] d;
    pulse_arm(10'd15);
    trig = 1'b1;
    P = 48'hFFFF_FFFF_FFFF;
    step();
    trig = 1'b0;
    repeat (5) step();
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL mid_capture_busy: busy=%b required 1", busy);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({rd_data, rd_valid, rd_last, busy, done} !== 12'h000) begin
      errors++; $display("FAIL async_reset: got %h required 000", {rd_data, rd_valid, rd_last, busy, done});
    end
    step();
    rst = 1'b1;
    step();
    trig = 1'b1;
    step();
    trig = 1'b0;
    repeat (3) step();
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++; $display("FAIL post_reset_idle: busy/done=%b required 00", {busy, done});
    end
    read_one(v, d, l);
    checks++;
    if (v !== 1'b0 || d !== 8'd0) begin
      errors++; $display("FAIL post_reset_read: valid=%b data=%0d required valid=0 data=0", v, d);
    end
  endtask
`else
  task automatic test_decim();
    logic v, l; logic [7:0] d, e;
    int c;
    P = '1;
    pulse_arm(10'd3);
    trig = 1'b1;
    step();
    trig = 1'b0;
    for (int i = 0; i < 4; i++) sb.push_back(8'd192);
    c = 0;
    while (!done && c < 40) begin
      step();
      c++;
    end
    checks++;
    if (c !== 16) begin
      errors++; $display("FAIL decim_done_latency: done after %0d cycles required 16", c);
    end
    for (int i = 0; i < 4; i++) begin
      read_one(v, d, l);
      e = sb.pop_front();
      checks++;
      if (v !== 1'b1 || d !== e || l !== (i == 3)) begin
        errors++;
        $display("FAIL decim_read%0d: valid=%b data=%0d last=%b required valid=1 data=%0d last=%b",
                 i, v, d, l, e, (i == 3));
      end
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
`ifndef SENSOR_DECIM_EN
    test_constant();
    test_incrementing();
    test_trig_before_arm();
    test_overread_arm_priority();
    test_full_depth();
    test_rst_mid_capture();
`else
    test_decim();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
